// File: rtl/cpu_core_mc.sv
// Multicycle 16x32 register CPU with a ready/ack memory bus.
// Control FSM and datapath share this module; one instruction is in flight at a time.
module cpu_core_mc #(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter bit                 R0_ZERO  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_en,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic              illegal,
    output logic              retired,
    output logic [ADDR_W-1:0] pc_o,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    localparam logic [3:0] OpAdd  = 4'h0;
    localparam logic [3:0] OpSub  = 4'h1;
    localparam logic [3:0] OpAnd  = 4'h2;
    localparam logic [3:0] OpOr   = 4'h3;
    localparam logic [3:0] OpXor  = 4'h4;
    localparam logic [3:0] OpSll  = 4'h5;
    localparam logic [3:0] OpSrl  = 4'h6;
    localparam logic [3:0] OpAddi = 4'h7;
    localparam logic [3:0] OpLui  = 4'h8;
    localparam logic [3:0] OpLw   = 4'h9;
    localparam logic [3:0] OpSw   = 4'hA;
    localparam logic [3:0] OpBeq  = 4'hB;
    localparam logic [3:0] OpJal  = 4'hC;
    localparam logic [3:0] OpHalt = 4'hD;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [31:0]         ir_q, ir_d, a_q, a_d, b_q, b_d, res_q, res_d, ea_q, ea_d;
    logic                illegal_q, illegal_d, pend_q, pend_d;
    logic [31:0]         rf_q [16];
    logic                rf_we;
    logic [31:0]         rf_wdata;

    logic [3:0]          op, rd, ra, rb;
    logic [15:0]         imm;
    logic [31:0]         sext, alu, ra_val, rb_val;
    logic [ADDR_W-1:0]   pc_plus4;

    assign op       = ir_q[31:28];
    assign rd       = ir_q[27:24];
    assign ra       = ir_q[23:20];
    assign rb       = ir_q[19:16];
    assign imm      = ir_q[15:0];
    assign sext     = {{16{imm[15]}}, imm};
    assign pc_plus4 = pc_q + ADDR_W'(4);
    assign ra_val   = (R0_ZERO && ra == 4'd0) ? 32'd0 : rf_q[ra];
    assign rb_val   = (R0_ZERO && rb == 4'd0) ? 32'd0 : rf_q[rb];

    always_comb begin
        alu = '0;
        unique case (op)
            OpAdd:   alu = a_q + b_q;
            OpSub:   alu = a_q - b_q;
            OpAnd:   alu = a_q & b_q;
            OpOr:    alu = a_q | b_q;
            OpXor:   alu = a_q ^ b_q;
            OpSll:   alu = a_q << b_q[4:0];
            OpSrl:   alu = a_q >> b_q[4:0];
            OpAddi:  alu = a_q + sext;
            OpLui:   alu = {imm, 16'h0000};
            default: alu = '0;
        endcase
    end

    // Bus outputs are decoded from state; reset gating makes mem_req drop at once.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst) begin
            if (state_q == StFetch && (run_en || pend_q)) begin
                mem_req  = 1'b1;
                mem_addr = {pc_q[ADDR_W-1:2], 2'b00};
            end else if (state_q == StMem) begin
                mem_req   = 1'b1;
                mem_we    = (op == OpSw);
                mem_addr  = {ea_q[ADDR_W-1:2], 2'b00};
                mem_wdata = b_q;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        ea_d      = ea_q;
        illegal_d = illegal_q;
        pend_d    = 1'b0;
        rf_we     = 1'b0;
        rf_wdata  = res_q;
        retired   = 1'b0;
        unique case (state_q)
            StFetch: begin
                // Once requested, a fetch stays on the bus until acked.
                pend_d = mem_req && !mem_ack;
                if (mem_req && mem_ack) begin
                    ir_d    = mem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d     = ra_val;
                b_d     = rb_val;
                state_d = StExec;
            end
            StExec: begin
                unique case (op)
                    OpLw, OpSw: begin
                        ea_d    = (a_q + sext) & 32'hFFFF_FFFC;
                        state_d = StMem;
                    end
                    OpBeq: begin
                        pc_d    = (a_q == b_q) ? pc_q + sext[ADDR_W-1:0] : pc_plus4;
                        retired = 1'b1;
                        state_d = StFetch;
                    end
                    OpJal: begin
                        rf_we    = 1'b1;
                        rf_wdata = 32'(pc_plus4);
                        pc_d     = {a_q[ADDR_W-1:2], 2'b00};
                        retired  = 1'b1;
                        state_d  = StFetch;
                    end
                    OpHalt: begin
                        retired = 1'b1;
                        state_d = StHalt;
                    end
                    4'hE, 4'hF: begin
                        illegal_d = 1'b1;
                        state_d   = StWb;
                    end
                    default: begin
                        res_d   = alu;
                        state_d = StWb;
                    end
                endcase
            end
            StMem: begin
                if (mem_ack) begin
                    if (op == OpSw) begin
                        pc_d    = pc_plus4;
                        retired = 1'b1;
                        state_d = StFetch;
                    end else begin
                        res_d   = mem_rdata;
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                // Illegal opcodes reach WB as NOPs and must not write Rd.
                rf_we   = (op <= OpLw);
                pc_d    = pc_plus4;
                retired = 1'b1;
                state_d = StFetch;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            ea_q      <= '0;
            illegal_q <= 1'b0;
            pend_q    <= 1'b0;
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            ea_q      <= ea_d;
            illegal_q <= illegal_d;
            pend_q    <= pend_d;
            if (rf_we && !(R0_ZERO && rd == 4'd0)) rf_q[rd] <= rf_wdata;
        end
    end

    assign halted  = (state_q == StHalt);
    assign illegal = illegal_q;
    assign pc_o    = pc_q;
    assign state_o = state_q;

endmodule
